// File: rtl/ps2_keyboard_tx.sv
// ----------------------------------------------------------------------------
// ps2_keyboard_tx
// Device-side PS/2 keyboard transmitter. Scan codes are accepted over a
// valid/ready handshake into a small FIFO and sent one at a time as 11-bit
// PS/2 frames (start 0, data LSB first, odd parity, stop 1). Both PS/2 lines
// are generated here and are registered.
//
// Parameters
//   CLK_DIV  system clocks per PS/2 half-period (>= 2)
//   GAP      idle clocks (clk=1, data=1) after every stop bit (>= 1)
//   FIFO_AW  FIFO address width, depth = 2**FIFO_AW (>= 1)
//
// Ports
//   clk       system clock, rising edge
//   resetn    asynchronous active-low reset
//   data      scan code, sampled only on an accepted push
//   valid     data is valid this cycle
//   ready     FIFO not full (push = valid && ready)
//   ps2_clk   PS/2 clock, idles high
//   ps2_data  PS/2 data, idles high, changes only at the start of a high phase
//   busy      frame in progress or bytes queued
// ----------------------------------------------------------------------------
module ps2_keyboard_tx #(
    parameter int CLK_DIV = 16,
    parameter int GAP     = 32,
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy
);

    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int CNT_MAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BIT_HI,
        S_BIT_LO,
        S_GAP
    } state_t;

    // ------------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------------
    logic [7:0]       r_mem [DEPTH];
    logic [FIFO_AW:0] r_wr_ptr;
    logic [FIFO_AW:0] r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [7:0]       w_rd_data;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign w_full    = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                       (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_push    = valid && !w_full;
    assign w_rd_data = r_mem[r_rd_ptr[FIFO_AW-1:0]];

    // NOTE: the storage array has no reset; only the pointers need one, so
    // the array maps onto plain RAM/flops without a reset network.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       r_bitcnt;
    logic [3:0]       w_bitcnt_nxt;
    logic [10:0]      r_shift;
    logic [10:0]      w_shift_nxt;
    logic             r_ps2_clk;
    logic             w_clk_nxt;
    logic             r_ps2_data;
    logic             w_data_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bitcnt   <= '0;
            r_shift    <= '1;
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_shift    <= w_shift_nxt;
            r_ps2_clk  <= w_clk_nxt;
            r_ps2_data <= w_data_nxt;
        end
    end

    // Line values are computed for the next state so the registered outputs
    // change on the same edge as the state they belong to.
    // NOTE: every signal gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + 1'b1;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_clk_nxt    = r_ps2_clk;
        w_data_nxt   = r_ps2_data;
        w_pop        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt  = '0;
                w_clk_nxt  = 1'b1;
                w_data_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    // {stop, odd parity, data, start}; bit 0 goes out first.
                    w_shift_nxt  = {1'b1, ~^w_rd_data, w_rd_data, 1'b0};
                    w_bitcnt_nxt = '0;
                    w_data_nxt   = 1'b0;
                    w_state_nxt  = S_BIT_HI;
                end
            end

            S_BIT_HI: begin
                if (r_cnt == DIV_LAST) begin
                    w_cnt_nxt   = '0;
                    w_clk_nxt   = 1'b0;
                    w_state_nxt = S_BIT_LO;
                end
            end

            S_BIT_LO: begin
                if (r_cnt == DIV_LAST) begin
                    w_cnt_nxt = '0;
                    w_clk_nxt = 1'b1;
                    if (r_bitcnt == 4'd10) begin
                        w_data_nxt  = 1'b1;
                        w_state_nxt = S_GAP;
                    end else begin
                        // Next bit is presented as the clock rises again.
                        w_shift_nxt  = {1'b1, r_shift[10:1]};
                        w_bitcnt_nxt = r_bitcnt + 1'b1;
                        w_data_nxt   = r_shift[1];
                        w_state_nxt  = S_BIT_HI;
                    end
                end
            end

            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign ready    = !w_full;
    assign busy     = (r_state != S_IDLE) || !w_empty;
    assign ps2_clk  = r_ps2_clk;
    assign ps2_data = r_ps2_data;

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// ----------------------------------------------------------------------------
// tb_ps2_keyboard_tx
// Directed bench for ps2_keyboard_tx with CLK_DIV=16, GAP=32. A line monitor
// acts as the PS/2 receiver: it samples ps2_data on every ps2_clk fall,
// collects 11-bit frames, logs start-bit and first-fall cycles, and counts
// data changes made while ps2_clk is low.
// ----------------------------------------------------------------------------
module tb_ps2_keyboard_tx;

    localparam int CD = 16;
    localparam int GP = 32;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    ps2_keyboard_tx #(
        .CLK_DIV (CD),
        .GAP     (GP),
        .FIFO_AW (2)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // Line monitor (receiver side)
    // ------------------------------------------------------------------------
    logic [10:0] frames[$];
    int          starts[$];
    int          falls[$];
    int          viol = 0;
    logic [3:0]  bitidx = 4'd0;
    logic [10:0] cur = '0;
    logic        prev_clk = 1'b1;
    logic        prev_data = 1'b1;

    always @(posedge clk) begin
        #1;
        if (!resetn) begin
            bitidx    = 4'd0;
            prev_clk  = 1'b1;
            prev_data = 1'b1;
        end else begin
            if (ps2_data !== prev_data && ps2_clk === 1'b0) viol++;
            if (prev_data && !ps2_data && bitidx == 4'd0 && ps2_clk) starts.push_back(cyc);
            if (prev_clk && !ps2_clk) begin
                if (bitidx == 4'd0) falls.push_back(cyc);
                cur[bitidx] = ps2_data;
                if (bitidx == 4'd10) begin
                    frames.push_back(cur);
                    bitidx = 4'd0;
                end else begin
                    bitidx = bitidx + 4'd1;
                end
            end
            prev_clk  = ps2_clk;
            prev_data = ps2_data;
        end
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    logic [7:0] tx_bytes[8];
    int         acc_edge[8];
    logic       rdy_after[8];

    task automatic clear_logs();
        frames.delete();
        starts.delete();
        falls.delete();
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) begin
            @(posedge clk); #1;
        end
    endtask

    // Holds valid high and presents tx_bytes[0..n-1] in turn; each byte moves
    // on only after an edge at which ready was high.
    task automatic send_list(input int n);
        logic r;
        for (int k = 0; k < n; k++) begin
            int t;
            t     = 0;
            r     = 1'b0;
            data  = tx_bytes[k];
            valid = 1'b1;
            while (!r && t < 2000) begin
                @(negedge clk);
                r = ready;
                @(posedge clk); #1;
                t++;
            end
            acc_edge[k]  = cyc;
            rdy_after[k] = ready;
            if (!r) begin
                n_checks++;
                $display("FAIL push_timeout: byte %0d never accepted", k);
            end
        end
        valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t;
        t = 0;
        while (frames.size() < n && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        n_checks++;
        if (frames.size() < n) $display("FAIL frame_wait: got %0d frames want %0d", frames.size(), n);
        else n_pass++;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        resetn = 1'b0;
        valid  = 1'b0;
        data   = 8'h00;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++; if (ps2_clk  !== 1'b1) $display("FAIL reset_clk: got %b want 1", ps2_clk);  else n_pass++;
        n_checks++; if (ps2_data !== 1'b1) $display("FAIL reset_data: got %b want 1", ps2_data); else n_pass++;
        n_checks++; if (ready    !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready);   else n_pass++;
        n_checks++; if (busy     !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);     else n_pass++;
        resetn = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++; if (busy !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_single();
        int          e;
        logic [10:0] got;
        clear_logs();
        tx_bytes[0] = 8'h1C;
        send_list(1);
        e = acc_edge[0];
        n_checks++; if (ps2_data !== 1'b1) $display("FAIL single_no_bypass: got %b want 1", ps2_data); else n_pass++;
        wait_to(e + 1);
        n_checks++; if (ps2_data !== 1'b0) $display("FAIL single_start_bit: got %b want 0", ps2_data); else n_pass++;
        n_checks++; if (ps2_clk  !== 1'b1) $display("FAIL single_start_clk: got %b want 1", ps2_clk);  else n_pass++;
        wait_frames(1, 1000);
        n_checks++; if (starts.size() == 0 || starts[0] != e + 1)  $display("FAIL single_start_cycle: got %0d want %0d", (starts.size() > 0) ? starts[0] - e : -1, 1);  else n_pass++;
        n_checks++; if (falls.size()  == 0 || falls[0]  != e + 17) $display("FAIL single_first_fall: got %0d want %0d", (falls.size() > 0) ? falls[0] - e : -1, 17); else n_pass++;
        // bits on the falls: 0,0,0,1,1,1,0,0,0,0,1 (bit 0 first)
        got = (frames.size() > 0) ? frames[0] : 11'h000;
        n_checks++; if (got !== 11'b1_0_00011100_0) $display("FAIL single_frame: got %b want %b", got, 11'b1_0_00011100_0); else n_pass++;
        // busy falls at E+1+352+GAP = E+385
        wait_to(e + 384);
        n_checks++; if (busy !== 1'b1) $display("FAIL single_busy_gap: got %b want 1", busy); else n_pass++;
        wait_to(e + 385);
        n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_fall: got %b want 0", busy); else n_pass++;
        n_checks++; if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) $display("FAIL single_idle_lines: got %b%b want 11", ps2_clk, ps2_data); else n_pass++;
        wait_idle();
    endtask

    task automatic test_parity();
        logic [10:0] exp_frame[4];
        logic        exp_par[4];
        logic [10:0] got;
        clear_logs();
        tx_bytes[0] = 8'h00; tx_bytes[1] = 8'hFF; tx_bytes[2] = 8'hF0; tx_bytes[3] = 8'h01;
        exp_frame[0] = 11'b1_1_00000000_0;
        exp_frame[1] = 11'b1_1_11111111_0;
        exp_frame[2] = 11'b1_1_11110000_0;
        exp_frame[3] = 11'b1_0_00000001_0;
        exp_par[0] = 1'b1; exp_par[1] = 1'b1; exp_par[2] = 1'b1; exp_par[3] = 1'b0;
        send_list(4);
        wait_frames(4, 2000);
        for (int i = 0; i < 4; i++) begin
            got = (frames.size() > i) ? frames[i] : 11'h000;
            n_checks++; if (got[9] !== exp_par[i]) $display("FAIL parity_bit_%0d: got %b want %b", i, got[9], exp_par[i]); else n_pass++;
            n_checks++; if (got !== exp_frame[i]) $display("FAIL parity_frame_%0d: got %b want %b", i, got, exp_frame[i]); else n_pass++;
        end
        wait_idle();
    endtask

    task automatic test_fifo_full();
        logic [7:0] exp_b[6];
        logic [7:0] got;
        clear_logs();
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        exp_b[3] = 8'h44; exp_b[4] = 8'h55; exp_b[5] = 8'h66;
        for (int i = 0; i < 6; i++) tx_bytes[i] = exp_b[i];
        send_list(6);
        n_checks++; if (acc_edge[4] - acc_edge[0] != 4) $display("FAIL full_first5_edges: got %0d want 4", acc_edge[4] - acc_edge[0]); else n_pass++;
        n_checks++; if (rdy_after[3] !== 1'b1) $display("FAIL full_ready_after4: got %b want 1", rdy_after[3]); else n_pass++;
        n_checks++; if (rdy_after[4] !== 1'b0) $display("FAIL full_ready_after5: got %b want 0", rdy_after[4]); else n_pass++;
        // second pop at E+386, ready back the cycle after, push at E+387
        n_checks++; if (acc_edge[5] - acc_edge[0] != 387) $display("FAIL full_sixth_accept: got %0d want 387", acc_edge[5] - acc_edge[0]); else n_pass++;
        wait_frames(6, 3000);
        for (int i = 0; i < 6; i++) begin
            got = (frames.size() > i) ? frames[i][8:1] : 8'h00;
            n_checks++; if (got !== exp_b[i]) $display("FAIL full_order_%0d: got %h want %h", i, got, exp_b[i]); else n_pass++;
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        clear_logs();
        tx_bytes[0] = 8'h12; tx_bytes[1] = 8'h34;
        send_list(2);
        wait_frames(2, 1200);
        // 22*16 + 32 + 1 = 385
        n_checks++; if (starts.size() < 2 || starts[1] - starts[0] != 385)
            $display("FAIL b2b_spacing: got %0d want 385", (starts.size() > 1) ? starts[1] - starts[0] : -1);
        else n_pass++;
        wait_idle();
    endtask

    task automatic test_reset_mid_frame();
        int          e;
        int          bad;
        logic [10:0] got;
        clear_logs();
        tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h3C;
        send_list(2);
        e = acc_edge[0];
        // data bit 4 low phase spans E+177..E+192 (line low, d4 = 0)
        wait_to(e + 180);
        n_checks++; if (ps2_clk !== 1'b0) $display("FAIL rst_mid_pre_clk: got %b want 0", ps2_clk); else n_pass++;
        resetn = 1'b0;
        #1;
        n_checks++; if (ps2_clk  !== 1'b1) $display("FAIL rst_mid_clk: got %b want 1", ps2_clk);   else n_pass++;
        n_checks++; if (ps2_data !== 1'b1) $display("FAIL rst_mid_data: got %b want 1", ps2_data); else n_pass++;
        n_checks++; if (ready    !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", ready);   else n_pass++;
        n_checks++; if (busy     !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy);     else n_pass++;
        repeat (2) begin @(posedge clk); #1; end
        resetn = 1'b1;
        clear_logs();
        bad = 0;
        repeat (600) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || ps2_data !== 1'b1) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL rst_mid_queue_flushed: got %0d busy/active cycles want 0", bad); else n_pass++;
        n_checks++; if (starts.size() != 0) $display("FAIL rst_mid_no_start: got %0d starts want 0", starts.size()); else n_pass++;
        tx_bytes[0] = 8'h5A;
        send_list(1);
        wait_frames(1, 1000);
        got = (frames.size() > 0) ? frames[0] : 11'h000;
        n_checks++; if (got !== 11'b1_1_01011010_0) $display("FAIL rst_mid_new_frame: got %b want %b", got, 11'b1_1_01011010_0); else n_pass++;
        wait_idle();
    endtask

    task automatic test_data_hold();
        int busy_seen;
        int not_ready;
        clear_logs();
        busy_seen = 0;
        not_ready = 0;
        valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            data = 8'(i * 37 + 5);
            @(posedge clk); #1;
            if (busy !== 1'b0) busy_seen++;
            if (ready !== 1'b1) not_ready++;
        end
        n_checks++; if (busy_seen != 0) $display("FAIL hold_busy: got %0d cycles want 0", busy_seen); else n_pass++;
        n_checks++; if (not_ready != 0) $display("FAIL hold_ready: got %0d cycles want 0", not_ready); else n_pass++;
        n_checks++; if (starts.size() != 0) $display("FAIL hold_no_frame: got %0d starts want 0", starts.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_fifo_full();
        test_back_to_back();
        test_reset_mid_frame();
        test_data_hold();
        n_checks++; if (viol != 0) $display("FAIL data_while_clk_low: got %0d changes want 0", viol); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_tx.md
# ps2_keyboard_tx

Device-side PS/2 keyboard transmitter: accepts 8-bit scan codes over a valid/ready handshake, buffers them in a small FIFO, and serialises each one as an 11-bit PS/2 frame. It generates both `ps2_clk` and `ps2_data`. It is the transmit-side counterpart of `ps2_keyboard` and drives that receiver's `ps2_clk`/`ps2_data` inputs directly in loopback and self-test builds of `top`.

## Interface
- `CLK_DIV`, default 16: system clocks per PS/2 half-period. Must be ≥ 2.
- `GAP`, default 32: system clocks of idle (clk=1, data=1) after each stop bit. Must be ≥ 1.
- `FIFO_AW`, default 2: FIFO address width, giving depth 2^FIFO_AW = 4.
- `clk` in 1: system clock; all logic is on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `data` in 8: scan code to send.
- `valid` in 1: `data` is valid this cycle.
- `ready` out 1: FIFO not full; a push happens when `valid && ready` at a clock edge.
- `ps2_clk` out 1: PS/2 clock, registered. Idles high.
- `ps2_data` out 1: PS/2 data, registered. Idles high.
- `busy` out 1: high when the state is not IDLE or the FIFO is non-empty.

## Operation
- Frame, in order: start bit 0, then `data[0]`..`data[7]` (LSB first), then an odd parity bit, then a stop bit 1. Parity = ~^data, so the total count of ones across the 8 data bits plus parity is odd.
- The receiver samples on the falling edge of `ps2_clk`. `ps2_data` therefore changes only while `ps2_clk` is high, at the start of each high phase.
- FSM states:
  - IDLE: clk=1, data=1. If the FIFO is non-empty: pop, load the 11-bit shift register, set `bitcnt`=0, go to BIT_HI.
  - BIT_HI: clk=1, data=current bit. After CLK_DIV cycles go to BIT_LO.
  - BIT_LO: clk=0, data unchanged. After CLK_DIV cycles:
    - if `bitcnt`=10, go to GAP;
    - otherwise shift, increment `bitcnt`, go to BIT_HI.
  - GAP: clk=1, data=1. After GAP cycles go to IDLE.
- FIFO:
  - synchronous, with read and write pointers of FIFO_AW+1 bits;
  - full = MSBs differ and low bits equal; empty = pointers equal;
  - push and pop in the same cycle are allowed, and the count is unchanged;
  - data is never dropped, because the source must respect `ready`;
  - no bypass: a push into an empty FIFO is still written first, then popped.
- `data` is sampled only on accepted pushes. Changes to `data` at other times have no effect.

## Timing
- Reset values (asserted asynchronously): `ps2_clk`=1, `ps2_data`=1, `ready`=1, `busy`=0, state=IDLE, FIFO empty, counters 0.
- Reset mid-frame: lines return to 1/1 immediately, the frame is truncated, and all queued bytes are discarded. After release, the block waits in IDLE with no gap.
- Latency, for a push accepted at edge E into an empty FIFO while in IDLE:
  - the pop happens at E+1;
  - `ps2_data`=0 (start bit) is visible after E+1;
  - the first `ps2_clk` fall is at E+1+CLK_DIV.
- One frame lasts 22·CLK_DIV cycles (from entering BIT_HI to entering GAP).
- Start-to-start spacing of back-to-back frames is 22·CLK_DIV + GAP + 1 cycles, because IDLE is always held for one cycle.
- `ready` is combinational from full. It deasserts in the cycle after the 4th unpopped push. It reasserts in the cycle after a pop frees a slot.
- `busy` falls in the cycle after GAP ends, and only if the FIFO is empty.
- The last `ps2_clk` rising edge of a frame coincides with entering GAP. `ps2_data` stays 1 from the stop bit through GAP.

## Test plan
- Single byte 0x1C, CLK_DIV=16: push at E. Required:
  - data sampled on the 11 `ps2_clk` falls = 0,0,0,1,1,1,0,0,0,0,1;
  - start bit visible at E+1;
  - first fall at E+17;
  - `busy` falls at E+1+352+GAP.
- Parity coverage: push 0x00, 0xFF, 0xF0, 0x01. Required parity bits = 1, 1, 1, 0. A `ps2_keyboard` instance in loopback must receive the same four bytes in order.
- FIFO full: push 6 bytes back-to-back with `valid` held high. Required:
  - `ready` low after 5 accepted pushes (4 queued plus 1 popped);
  - the remaining byte is accepted only after the next frame pops;
  - all 6 bytes are sent in order.
- Back-to-back spacing: 2 bytes queued. Required: the second start bit begins exactly 22·CLK_DIV + GAP + 1 cycles after the first start bit.
- Reset mid-frame: assert `resetn`=0 during data bit 4. Required:
  - `ps2_clk`=`ps2_data`=1 and `ready`=1 immediately;
  - `busy`=0;
  - the queued second byte is not sent;
  - a new push after release sends a complete, correct frame.
- Data hold: change `data` every cycle while `valid`=0. Required: no frame is ever started.
